// File: rtl/hazard_stall_controller.sv
// Pipeline sequencing controller for the five-stage MIPS datapath: decides each cycle
// which inter-stage latches advance, hold or take a bubble (load-use, branch, memory wait, halt).
module hazard_stall_controller #(
  parameter int unsigned MEM_TIMEOUT  = 15,
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt_rd,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             halt_req,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_write,
  output logic             mem_wb_bubble,
  output logic             halted,
  output logic             mem_error,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_count
);

  localparam int unsigned WAIT_W  = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [WAIT_W-1:0]  WAIT_MAX   = WAIT_W'(MEM_TIMEOUT);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_DRAIN  = 2'b01,
    ST_HALTED = 2'b10,
    ST_UNUSED = 2'b11
  } state_e;

  state_e             state_q, state_d, cur_st;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
  logic [CNT_W-1:0]   stall_count_q, stall_count_d;
  logic               mem_error_q, mem_error_d;

  logic load_use;
  logic mem_wait;
  logic timeout;
  logic freeze;

  // The unused encoding behaves exactly like RUN.
  always_comb begin
    case (state_q)
      ST_DRAIN:  cur_st = ST_DRAIN;
      ST_HALTED: cur_st = ST_HALTED;
      default:   cur_st = ST_RUN;
    endcase
  end

  assign load_use = ex_mem_read && (ex_rt_rd != 5'd0) &&
                    ((id_uses_rs && (id_rs == ex_rt_rd)) ||
                     (id_uses_rt && (id_rt == ex_rt_rd)));
  assign mem_wait = mem_req && !mem_ready;
  assign timeout  = (wait_cnt_q == WAIT_MAX);
  assign freeze   = mem_wait && !timeout;

  // NOTE: every output and next-state signal gets a default first so no path leaves one unassigned (no latches).
  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    ex_mem_write  = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    mem_wb_bubble = 1'b0;
    state_d       = cur_st;
    drain_cnt_d   = drain_cnt_q;
    wait_cnt_d    = '0;
    mem_error_d   = mem_error_q | (mem_wait & timeout);

    if (freeze) begin
      // Memory wait: hold everything upstream of MEM, push bubbles into WB.
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      ex_mem_write  = 1'b0;
      mem_wb_bubble = 1'b1;
      wait_cnt_d    = wait_cnt_q + 1'b1;
    end else begin
      case (cur_st)
        ST_DRAIN: begin
          pc_write    = ex_branch_taken;
          if_id_write = 1'b0;
          if_id_flush = ex_branch_taken;
          id_ex_flush = 1'b1;
          if (!halt_req) begin
            state_d = ST_RUN;
          end else if (drain_cnt_q == DRAIN_LAST) begin
            state_d = ST_HALTED;
          end else begin
            drain_cnt_d = drain_cnt_q + 1'b1;
          end
        end
        ST_HALTED: begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_flush = 1'b1;
          if (!halt_req) state_d = ST_RUN;
        end
        default: begin
          if (ex_branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (load_use) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
          end
          if (halt_req) begin
            state_d     = ST_DRAIN;
            drain_cnt_d = '0;
          end
        end
      endcase
    end

    stall_count_d = stall_count_q;
    if (!pc_write && (cur_st != ST_HALTED) && !(&stall_count_q)) begin
      stall_count_d = stall_count_q + 1'b1;
    end

    // While reset is held every latch is written with its cleared value.
    if (reset) begin
      pc_write      = 1'b1;
      if_id_write   = 1'b1;
      ex_mem_write  = 1'b1;
      if_id_flush   = 1'b1;
      id_ex_flush   = 1'b1;
      mem_wb_bubble = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_RUN;
      wait_cnt_q    <= '0;
      drain_cnt_q   <= '0;
      stall_count_q <= '0;
      mem_error_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      drain_cnt_q   <= drain_cnt_d;
      stall_count_q <= stall_count_d;
      mem_error_q   <= mem_error_d;
    end
  end

  assign state       = reset ? ST_RUN : cur_st;
  assign halted      = !reset && (cur_st == ST_HALTED);
  assign mem_error   = !reset && mem_error_q;
  assign stall_count = reset ? '0 : stall_count_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Self-checking bench for hazard_stall_controller: directed scenarios followed by
// randomized traffic, all compared against a cycle-level behavioural model.
module tb_hazard_stall_controller;

  localparam int MEM_TIMEOUT  = 15;
  localparam int DRAIN_CYCLES = 3;
  localparam int CNT_W        = 6;
  localparam int STALL_MAX    = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic [4:0]       id_rs, id_rt, ex_rt_rd;
  logic             id_uses_rs, id_uses_rt, ex_mem_read, ex_branch_taken;
  logic             mem_req, mem_ready, halt_req;
  logic             pc_write, if_id_write, if_id_flush, id_ex_flush;
  logic             ex_mem_write, mem_wb_bubble, halted, mem_error;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_count;

  int checks = 0;
  int errors = 0;

  // Model state: 0 run, 1 drain, 2 halted.
  int m_state = 0;
  int m_wait  = 0;
  int m_drain = 0;
  int m_stall = 0;
  int m_err   = 0;

  always #5 clk = ~clk;

  hazard_stall_controller #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .DRAIN_CYCLES(DRAIN_CYCLES),
    .CNT_W       (CNT_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_uses_rs     (id_uses_rs),
    .id_uses_rt     (id_uses_rt),
    .ex_mem_read    (ex_mem_read),
    .ex_rt_rd       (ex_rt_rd),
    .ex_branch_taken(ex_branch_taken),
    .mem_req        (mem_req),
    .mem_ready      (mem_ready),
    .halt_req       (halt_req),
    .pc_write       (pc_write),
    .if_id_write    (if_id_write),
    .if_id_flush    (if_id_flush),
    .id_ex_flush    (id_ex_flush),
    .ex_mem_write   (ex_mem_write),
    .mem_wb_bubble  (mem_wb_bubble),
    .halted         (halted),
    .mem_error      (mem_error),
    .state          (state),
    .stall_count    (stall_count)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic idle_inputs();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    ex_mem_read = 1'b0; ex_rt_rd = 5'd0; ex_branch_taken = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0; halt_req = 1'b0;
  endtask

  // Called at a falling edge with inputs already applied: checks the outputs,
  // advances the model across the rising edge, returns at the next falling edge.
  task automatic step(input string tag);
    bit lu, mw, tmo, frz;
    bit e_pc, e_ifw, e_iff, e_idf, e_exw, e_bub;
    #1;
    lu  = ex_mem_read && (ex_rt_rd != 0) &&
          ((id_uses_rs && id_rs == ex_rt_rd) || (id_uses_rt && id_rt == ex_rt_rd));
    mw  = mem_req && !mem_ready;
    tmo = (m_wait == MEM_TIMEOUT);
    frz = mw && !tmo;
    {e_pc, e_ifw, e_exw, e_iff, e_idf, e_bub} = 6'b111000;
    if (reset)                 {e_pc, e_ifw, e_exw, e_iff, e_idf, e_bub} = 6'b111111;
    else if (frz)              {e_pc, e_ifw, e_exw, e_bub} = 4'b0001;
    else if (m_state == 2)     {e_pc, e_ifw, e_idf} = 3'b001;
    else if (m_state == 1)     {e_pc, e_ifw, e_iff, e_idf} = {ex_branch_taken, 1'b0, ex_branch_taken, 1'b1};
    else if (ex_branch_taken)  {e_iff, e_idf} = 2'b11;
    else if (lu)               {e_pc, e_ifw, e_idf} = 3'b001;

    check({tag, ".ctrl"},
          {26'd0, pc_write, if_id_write, ex_mem_write, if_id_flush, id_ex_flush, mem_wb_bubble},
          {26'd0, e_pc, e_ifw, e_exw, e_iff, e_idf, e_bub});
    check({tag, ".state"},  {30'd0, state}, reset ? 32'd0 : 32'(m_state));
    check({tag, ".halted"}, {31'd0, halted}, (!reset && m_state == 2) ? 32'd1 : 32'd0);
    check({tag, ".err"},    {31'd0, mem_error}, (!reset && m_err != 0) ? 32'd1 : 32'd0);
    check({tag, ".stalls"}, 32'(stall_count), reset ? 32'd0 : 32'(m_stall));

    @(posedge clk);
    if (reset) begin
      m_state = 0; m_wait = 0; m_drain = 0; m_stall = 0; m_err = 0;
    end else begin
      m_wait = frz ? m_wait + 1 : 0;
      if (mw && tmo) m_err = 1;
      if (!e_pc && m_state != 2 && m_stall < STALL_MAX) m_stall++;
      if (!frz) begin
        if (m_state == 0) begin
          if (halt_req) begin m_state = 1; m_drain = 0; end
        end else if (m_state == 1) begin
          if (!halt_req)                       m_state = 0;
          else if (m_drain == DRAIN_CYCLES - 1) m_state = 2;
          else                                  m_drain++;
        end else if (!halt_req) begin
          m_state = 0;
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    bit slow;
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    step("rst0");
    step("rst1");
    reset = 1'b0;
    step("post_rst");

    // Load to r5 in EX, ID reads r5: one bubble, then the load has moved on.
    ex_mem_read = 1'b1; ex_rt_rd = 5'd5; id_rs = 5'd5; id_uses_rs = 1'b1;
    step("load_use");
    ex_mem_read = 1'b0;
    step("load_moved");
    check("lu_count", 32'(stall_count), 32'd1);

    // Load targeting r0 never stalls.
    ex_mem_read = 1'b1; ex_rt_rd = 5'd0; id_rs = 5'd0;
    step("load_r0");

    // Branch and load-use together: branch flush wins, no stall counted.
    ex_rt_rd = 5'd5; id_rt = 5'd5; id_uses_rt = 1'b1; id_rs = 5'd9; ex_branch_taken = 1'b1;
    step("br_lu");
    idle_inputs();
    step("br_after");
    check("br_count", 32'(stall_count), 32'd1);

    // Memory ready on the 4th cycle: three freeze cycles then release.
    mem_req = 1'b1;
    for (int i = 0; i < 3; i++) step("mem_wait");
    mem_ready = 1'b1;
    step("mem_rel");
    idle_inputs();
    step("mem_done");
    check("wait_count", 32'(stall_count), 32'd4);
    check("wait_err", {31'd0, mem_error}, 32'd0);

    // Memory stuck: MEM_TIMEOUT freezes, forced release, sticky error.
    mem_req = 1'b1;
    for (int i = 0; i < MEM_TIMEOUT + 1; i++) step("mem_stuck");
    idle_inputs();
    check("tmo_err", {31'd0, mem_error}, 32'd1);
    step("tmo_after");
    step("tmo_hold");
    check("tmo_count", 32'(stall_count), 32'(4 + MEM_TIMEOUT));

    // Halt held: DRAIN cycles, then halted; release resumes RUN.
    halt_req = 1'b1;
    id_rs = 5'd7; id_uses_rs = 1'b1;
    for (int i = 0; i < 1 + DRAIN_CYCLES; i++) step("halt_in");
    check("halted_now", {31'd0, halted}, 32'd1);
    check("halted_state", {30'd0, state}, 32'd2);
    step("halted1");
    step("halted2");
    halt_req = 1'b0;
    step("unhalt");
    check("resume_state", {30'd0, state}, 32'd0);
    step("resumed");

    // Halt abandoned in the 2nd DRAIN cycle.
    halt_req = 1'b1;
    step("abort_run");
    step("abort_d1");
    halt_req = 1'b0;
    step("abort_d2");
    step("abort_run2");

    // Freeze and branch together: freeze wins, branch acts on release.
    mem_req = 1'b1; ex_branch_taken = 1'b1;
    step("frz_br");
    mem_ready = 1'b1;
    step("frz_br_rel");
    idle_inputs();

    // Reset in the middle of a memory wait.
    mem_req = 1'b1;
    for (int i = 0; i < 7; i++) step("wait7");
    reset = 1'b1;
    step("rst_mid");
    reset = 1'b0;
    idle_inputs();
    step("rst_mid_after");
    check("rst_stalls", 32'(stall_count), 32'd0);

    // Randomized traffic; small register range keeps load-use frequent.
    slow = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      reset           = ($urandom_range(0, 299) == 0);
      id_rs           = 5'($urandom_range(0, 3));
      id_rt           = 5'($urandom_range(0, 3));
      id_uses_rs      = 1'($urandom);
      id_uses_rt      = 1'($urandom);
      ex_mem_read     = ($urandom_range(0, 2) == 0);
      ex_rt_rd        = 5'($urandom_range(0, 3));
      ex_branch_taken = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 39) == 0) slow = !slow;
      mem_req         = ($urandom_range(0, 2) == 0);
      mem_ready       = slow ? 1'b0 : 1'($urandom);
      if ($urandom_range(0, 19) == 0) halt_req = !halt_req;
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
